// File: rtl/maze_dfs_sequencer.sv
// Depth-first maze carve sequencer: drives an external carver one cell at a time, backtracking through a LIFO stack.
// Optional build macro MAZE_SEQ_TIMEOUT_EN adds a sticky timeout output and a WAIT watchdog counter.
module maze_dfs_sequencer #(
    parameter int MAZE_W      = 128,
    parameter int MAZE_H      = 64,
    parameter int STACK_DEPTH = 256,
    parameter int START_X     = 0,
    parameter int START_Y     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       step_req,
    output logic [6:0] cur_x,
    output logic [5:0] cur_y,
    input  logic       step_ack,
    input  logic       step_moved,
    input  logic [6:0] new_x,
    input  logic [5:0] new_y,
    output logic [8:0] depth,
    output logic       busy,
    output logic       finish,
    output logic       overflow
`ifdef MAZE_SEQ_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // Coordinate ports are fixed at 7/6 bits and depth at 9 bits, so geometry is bounded.
    if (MAZE_W < 1 || MAZE_W > 128 || MAZE_H < 1 || MAZE_H > 64 ||
        STACK_DEPTH < 2 || STACK_DEPTH > 256 ||
        (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_params
        $error("maze_dfs_sequencer: unsupported geometry or stack depth");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, POP, DONE, ERR} state_t;

    state_t      state, state_next;
    logic [12:0] stack_mem [STACK_DEPTH];
    logic [AW-1:0] top_addr;
    logic        do_start, do_push, do_pop, set_ovf;

`ifdef MAZE_SEQ_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        set_timeout;
`endif

    assign top_addr = depth[AW-1:0] - AW'(1);

    always_comb begin
        state_next = state;
        step_req   = 1'b0;
        busy       = 1'b0;
        finish     = 1'b0;
        do_start   = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_ovf    = 1'b0;
`ifdef MAZE_SEQ_TIMEOUT_EN
        set_timeout = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                finish = (state == DONE);
                if (start) begin
                    do_start   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                step_req   = 1'b1;
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (step_ack) begin
                    if (step_moved) begin
                        if (depth == 9'(STACK_DEPTH)) begin
                            set_ovf    = 1'b1;
                            state_next = ERR;
                        end else begin
                            do_push    = 1'b1;
                            state_next = ISSUE;
                        end
                    end else if (depth == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = POP;
                    end
                end
`ifdef MAZE_SEQ_TIMEOUT_EN
                // Counter holds N-1 during the Nth silent WAIT cycle.
                else if (wait_cnt == 16'hFFFE) begin
                    set_timeout = 1'b1;
                    state_next  = ERR;
                end
`endif
            end
            POP: begin
                busy       = 1'b1;
                do_pop     = 1'b1;
                state_next = ISSUE;
            end
            ERR: state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cur_x    <= 7'(START_X);
            cur_y    <= 6'(START_Y);
            depth    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (do_start) begin
                cur_x <= 7'(START_X);
                cur_y <= 6'(START_Y);
                depth <= '0;
            end
            if (do_push) begin
                cur_x <= new_x;
                cur_y <= new_y;
                depth <= depth + 9'd1;
            end
            if (do_pop) begin
                {cur_x, cur_y} <= stack_mem[top_addr];
                depth          <= depth - 9'd1;
            end
            if (set_ovf) overflow <= 1'b1;
        end
    end

    // Stack RAM: no reset, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!reset && do_push) stack_mem[depth[AW-1:0]] <= {cur_x, cur_y};
    end

`ifdef MAZE_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state == ISSUE) wait_cnt <= '0;
            else if (state == WAIT && !step_ack) wait_cnt <= wait_cnt + 16'd1;
            if (set_timeout) timeout <= 1'b1;
        end
    end
`endif

endmodule
